// File: rtl/sram_axi_bridge_if.sv
// Single-beat AXI read/write channel bundle between the SRAM bridge and the bus.
// len/size/burst/last are tied off outside the block, so they are not carried here.
interface sram_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arvalid, rready, awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );

  modport slave (
    input  arid, araddr, arvalid, rready, awid, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Turns the core's single-cycle inst/data SRAM ports into serialised single-beat AXI
// transactions, freezing the pipeline via stallreq until both accesses are done.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID  = 4'd0,
  parameter logic [3:0] DATA_ID  = 4'd1,
  parameter int         MAP_KSEG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_sram_en,
  input  logic [31:0]              inst_sram_addr,
  output logic [31:0]              inst_sram_rdata,
  input  logic                     data_sram_en,
  input  logic [3:0]               data_sram_wen,
  input  logic [31:0]              data_sram_addr,
  input  logic [31:0]              data_sram_wdata,
  output logic [31:0]              data_sram_rdata,
  output logic                     stallreq,
  sram_axi_bridge_if.master        axi
);

  typedef enum logic [2:0] {IDLE, D_AR, D_R, D_AW, D_B, I_AR, I_R, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] inst_addr_q, data_addr_q, wdata_q;
  logic [3:0]  wen_q;
  logic        pend_inst_q, aw_done_q, w_done_q;
  logic        req;

  assign req = inst_sram_en | data_sram_en;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto the low 512 MB
  function automatic logic [31:0] map_addr(input logic [31:0] va);
    if (MAP_KSEG != 0 && va[31:30] == 2'b10) return {3'b000, va[28:0]};
    return va;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_addr_q     <= '0;
      data_addr_q     <= '0;
      wdata_q         <= '0;
      wen_q           <= '0;
      pend_inst_q     <= 1'b0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        inst_addr_q <= map_addr(inst_sram_addr);
        data_addr_q <= map_addr(data_sram_addr);
        wdata_q     <= data_sram_wdata;
        wen_q       <= data_sram_wen;
        pend_inst_q <= inst_sram_en;
        aw_done_q   <= 1'b0;
        w_done_q    <= 1'b0;
      end
      // AW and W complete independently; remember which one is already through
      if (state == D_AW) begin
        if (axi.awvalid && axi.awready) aw_done_q <= 1'b1;
        if (axi.wvalid  && axi.wready)  w_done_q  <= 1'b1;
      end
      if (state == D_R && axi.rvalid) data_sram_rdata <= axi.rdata;
      if (state == I_R && axi.rvalid) inst_sram_rdata <= axi.rdata;
    end
  end

  assign axi.awid   = DATA_ID;
  assign axi.awaddr = data_addr_q;
  assign axi.wdata  = wdata_q;
  assign axi.wstrb  = wen_q;

  always_comb begin
    state_nxt   = state;
    stallreq    = 1'b1;
    axi.arvalid = 1'b0;
    axi.arid    = DATA_ID;
    axi.araddr  = data_addr_q;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    case (state)
      IDLE: begin
        stallreq = req;
        if (data_sram_en && data_sram_wen != 4'd0) state_nxt = D_AW;
        else if (data_sram_en)                     state_nxt = D_AR;
        else if (inst_sram_en)                     state_nxt = I_AR;
      end
      D_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_nxt = D_R;
      end
      D_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_nxt = pend_inst_q ? I_AR : DONE;
      end
      D_AW: begin
        axi.awvalid = ~aw_done_q;
        axi.wvalid  = ~w_done_q;
        if ((aw_done_q || axi.awready) && (w_done_q || axi.wready)) state_nxt = D_B;
      end
      D_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_nxt = pend_inst_q ? I_AR : DONE;
      end
      I_AR: begin
        axi.arvalid = 1'b1;
        axi.arid    = INST_ID;
        axi.araddr  = inst_addr_q;
        if (axi.arready) state_nxt = I_R;
      end
      I_R: begin
        axi.rready = 1'b1;
        axi.arid   = INST_ID;
        axi.araddr = inst_addr_q;
        if (axi.rvalid) state_nxt = DONE;
      end
      DONE: begin
        // one unstalled cycle lets the core advance; requests here are re-presented in IDLE
        stallreq  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Bench for sram_axi_bridge: table of core requests plus hand sequences, with an AXI
// slave model that checks every address/data handshake against an expectation queue.
module tb_sram_axi_bridge;

  typedef struct {
    string       name;
    logic        i_en;
    logic [31:0] i_addr;
    logic [31:0] i_pa;
    logic        d_en;
    logic [3:0]  wen;
    logic [31:0] d_addr;
    logic [31:0] d_pa;
    logic [31:0] wdata;
    int          busy;
  } vec_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
  } ar_t;

  logic        clk, rst;
  logic        inst_sram_en, data_sram_en;
  logic [31:0] inst_sram_addr, data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wen;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        stallreq;
  logic [31:0] m_irdata, m_drdata;
  logic        m_stall;

  sram_axi_bridge_if s();
  sram_axi_bridge_if m_if();

  sram_axi_bridge u_dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .stallreq(stallreq), .axi(s)
  );

  sram_axi_bridge #(.MAP_KSEG(0)) u_nomap (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(m_irdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(m_drdata),
    .stallreq(m_stall), .axi(m_if)
  );

  // always-ready slave for the unmapped instance
  assign m_if.arready = 1'b1;
  assign m_if.rvalid  = 1'b1;
  assign m_if.rdata   = 32'h1234_5678;
  assign m_if.awready = 1'b1;
  assign m_if.wready  = 1'b1;
  assign m_if.bvalid  = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  ar_t exp_ar[$], exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ird = '0, exp_drd = '0;
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int n_arv = 0, n_awv = 0, n_wv = 0, n_brd = 0;
  bit map_chk = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bad(input string nm, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %h with nothing expected at %0t", nm, act, $time);
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h2408_0001;
    return {a[15:0], ~a[31:16]};
  endfunction

  // slave model: updates on negedge, so every handshake lands on the following posedge
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit r_pend, aw_got, w_got;
  logic [31:0] r_addr, ar_first;
  always @(negedge clk) begin
    ar_t e;
    logic [35:0] ew;
    if (rst) begin
      s.arready = 0; s.rvalid = 0; s.rdata = '0; s.awready = 0; s.wready = 0; s.bvalid = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; aw_got = 0; w_got = 0; r_addr = '0; ar_first = '0;
    end else begin
      if (s.arvalid) n_arv++;
      if (s.awvalid) n_awv++;
      if (s.wvalid)  n_wv++;
      if (s.bready)  n_brd++;
      if (s.arready) begin
        s.arready = 0; r_pend = 1; r_cnt = 0;
      end else if (s.arvalid) begin
        if (ar_cnt == 0) ar_first = s.araddr;
        if (ar_cnt >= ar_delay) begin
          chk("ar_stable", s.araddr, ar_first);
          if (exp_ar.size() == 0) bad("ar_unexpected", s.araddr);
          else begin
            e = exp_ar.pop_front();
            chk("arid", s.arid, e.id);
            chk("araddr", s.araddr, e.addr);
          end
          r_addr = s.araddr; s.arready = 1; ar_cnt = 0;
        end else ar_cnt++;
      end
      if (s.rvalid) s.rvalid = 0;
      else if (r_pend) begin
        if (r_cnt >= r_delay) begin s.rvalid = 1; s.rdata = rd_fn(r_addr); r_pend = 0; end
        else r_cnt++;
      end
      if (s.awready) begin
        s.awready = 0; aw_got = 1;
      end else if (s.awvalid) begin
        if (aw_cnt >= aw_delay) begin
          if (exp_aw.size() == 0) bad("aw_unexpected", s.awaddr);
          else begin
            e = exp_aw.pop_front();
            chk("awid", s.awid, e.id);
            chk("awaddr", s.awaddr, e.addr);
          end
          s.awready = 1; aw_cnt = 0;
        end else aw_cnt++;
      end
      if (s.wready) begin
        s.wready = 0; w_got = 1;
      end else if (s.wvalid) begin
        if (w_cnt >= w_delay) begin
          if (exp_w.size() == 0) bad("w_unexpected", s.wdata);
          else begin
            ew = exp_w.pop_front();
            chk("wdata_wstrb", {s.wdata, s.wstrb}, ew);
          end
          s.wready = 1; w_cnt = 0;
        end else w_cnt++;
      end
      if (s.bvalid) s.bvalid = 0;
      else if (aw_got && w_got) begin
        if (b_cnt >= b_delay) begin s.bvalid = 1; aw_got = 0; w_got = 0; b_cnt = 0; end
        else b_cnt++;
      end
    end
  end

  task automatic do_req(input vec_t v);
    int busy;
    bit done;
    if (v.d_en && v.wen != 0) begin
      exp_aw.push_back(ar_t'{id: 4'd1, addr: v.d_pa});
      exp_w.push_back({v.wdata, v.wen});
    end else if (v.d_en) begin
      exp_ar.push_back(ar_t'{id: 4'd1, addr: v.d_pa});
      exp_drd = rd_fn(v.d_pa);
    end
    if (v.i_en) begin
      exp_ar.push_back(ar_t'{id: 4'd0, addr: v.i_pa});
      exp_ird = rd_fn(v.i_pa);
    end
    @(negedge clk); #1;
    inst_sram_en = v.i_en; inst_sram_addr = v.i_addr;
    data_sram_en = v.d_en; data_sram_wen = v.wen; data_sram_addr = v.d_addr; data_sram_wdata = v.wdata;
    #1 chk({v.name, "_stall_idle"}, stallreq, 1);
    busy = 0;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk); #1;
      if (c == 0 && map_chk) begin
        chk("nomap_arvalid", m_if.arvalid, 1);
        chk("nomap_araddr", m_if.araddr, v.i_addr);
      end
      if (stallreq) busy++;
      else done = 1;
    end
    if (!done) bad({v.name, "_timeout"}, busy);
    chk({v.name, "_busy"}, busy, v.busy);
    chk({v.name, "_inst_rdata"}, inst_sram_rdata, exp_ird);
    chk({v.name, "_data_rdata"}, data_sram_rdata, exp_drd);
    chk({v.name, "_drained"}, exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
    inst_sram_en = 0; data_sram_en = 0; data_sram_wen = 0;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t v;
    int a0, w0, b0, done;
    tbl[0] = '{"fetch",       1, 32'hBFC0_0000, 32'h1FC0_0000, 0, 4'h0, 32'h0,          32'h0,          32'h0,          2};
    tbl[1] = '{"load_fetch",  1, 32'hBFC0_0004, 32'h1FC0_0004, 1, 4'h0, 32'h8000_1000, 32'h0000_1000, 32'h0,          4};
    tbl[2] = '{"load",        0, 32'h0,          32'h0,          1, 4'h0, 32'hA000_0010, 32'h0000_0010, 32'h0,          2};
    tbl[3] = '{"store_fetch", 1, 32'h0040_0000, 32'h0040_0000, 1, 4'hF, 32'h8000_2000, 32'h0000_2000, 32'h1234_5678, 4};
    tbl[4] = '{"load_kseg2",  0, 32'h0,          32'h0,          1, 4'h0, 32'hC000_0000, 32'hC000_0000, 32'h0,          2};
    tbl[5] = '{"fetch_top",   1, 32'hBFFF_FFFC, 32'h1FFF_FFFC, 0, 4'h0, 32'h0,          32'h0,          32'h0,          2};

    rst = 1; inst_sram_en = 0; data_sram_en = 0; data_sram_wen = 0;
    inst_sram_addr = 0; data_sram_addr = 0; data_sram_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valids", {s.arvalid, s.rready, s.awvalid, s.wvalid, s.bready}, 0);
    chk("rst_inst_rdata", inst_sram_rdata, 0);
    chk("rst_data_rdata", data_sram_rdata, 0);
    chk("rst_stall", stallreq, 0);
    inst_sram_en = 1;
    #1 chk("rst_stall_en", stallreq, 1);
    inst_sram_en = 0;
    @(negedge clk); #1 rst = 0;

    for (int i = 0; i < 6; i++) do_req(tbl[i]);

    // store with slow AW, immediate W, delayed B
    aw_delay = 3; b_delay = 2;
    a0 = n_awv; w0 = n_wv; b0 = n_brd;
    v = '{"store", 0, 32'h0, 32'h0, 1, 4'b0011, 32'h8000_0020, 32'h0000_0020, 32'hDEAD_BEEF, 7};
    do_req(v);
    chk("store_awvalid_cycles", n_awv - a0, 4);
    chk("store_wvalid_cycles", n_wv - w0, 1);
    chk("store_bready_cycles", n_brd - b0, 3);
    aw_delay = 0; b_delay = 0;

    // read backpressure on a fetch
    ar_delay = 5; r_delay = 4;
    a0 = n_arv;
    v = '{"bp_fetch", 1, 32'hBFC0_0010, 32'h1FC0_0010, 0, 4'h0, 32'h0, 32'h0, 32'h0, 11};
    do_req(v);
    chk("bp_arvalid_cycles", n_arv - a0, 6);
    ar_delay = 0;

    // reset while waiting in D_R
    r_delay = 10;
    exp_ar.push_back(ar_t'{id: 4'd1, addr: 32'h0000_3000});
    @(negedge clk); #1;
    data_sram_en = 1; data_sram_addr = 32'h8000_3000; data_sram_wen = 0;
    done = 0;
    for (int c = 0; c < 50 && done == 0; c++) begin
      @(negedge clk); #1;
      if (s.rready) done = 1;
    end
    if (done == 0) bad("rst_reach_dr", 0);
    rst = 1;
    #1;
    chk("midrst_valids", {s.arvalid, s.rready, s.awvalid, s.wvalid, s.bready}, 0);
    chk("midrst_stall_en", stallreq, 1);
    data_sram_en = 0;
    #1 chk("midrst_stall_noen", stallreq, 0);
    chk("midrst_data_rdata", data_sram_rdata, 0);
    repeat (2) @(negedge clk);
    #1 rst = 0;
    r_delay = 0; exp_ird = '0; exp_drd = '0;
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    v = '{"post_rst", 1, 32'hBFC0_0008, 32'h1FC0_0008, 0, 4'h0, 32'h0, 32'h0, 32'h0, 2};
    do_req(v);

    // unmapped instance sees the raw virtual address
    repeat (8) @(negedge clk);
    map_chk = 1;
    v = '{"nomap", 1, 32'hBFC0_0000, 32'h1FC0_0000, 0, 4'h0, 32'h0, 32'h0, 32'h0, 2};
    do_req(v);
    map_chk = 0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
